// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester handshakes and FIFO write-port signals shared by the write arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DSIZE = 8
);
  localparam int unsigned IdW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wFull;
  logic                  winc;
  logic [DSIZE-1:0]      wData;
  logic [NREQ-1:0]       grant;
  logic [IdW-1:0]        grant_id;
  logic                  busy;

  modport master (
    input  req_valid,
    input  req_last,
    input  req_data,
    input  wFull,
    output req_ready,
    output winc,
    output wData,
    output grant,
    output grant_id,
    output busy
  );

  modport slave (
    output req_valid,
    output req_last,
    output req_data,
    output wFull,
    input  req_ready,
    input  winc,
    input  wData,
    input  grant,
    input  grant_id,
    input  busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing an async FIFO write port among NREQ write-domain requesters,
// holding each grant for up to BURST_MAX words or until the requester flags its last word.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic               wclk,
  input  logic               wrst,
  fifo_wr_arbiter_if.master  bus
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(BURST_MAX) + 1;
  localparam logic [CntW-1:0] BeatLast = CntW'(BURST_MAX - 1);
  localparam logic [IdW-1:0]  IdLast   = IdW'(NREQ - 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IdW-1:0]    grant_id_q, grant_id_d;
  logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
  logic              busy_q, busy_d;

  logic              pick_found;
  logic [IdW-1:0]    pick_id;
  logic [NREQ-1:0]   pick_onehot;
  int unsigned       scan_idx;
  logic              winc;
  logic              release_now;

  // grant_id doubles as the round-robin pointer: it keeps the last winner while idle,
  // so scanning starts one past the requester that was just released.
  always_comb begin
    pick_found  = 1'b0;
    pick_id     = grant_id_q;
    scan_idx    = 0;
    pick_onehot = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      scan_idx = (32'(grant_id_q) + i) % NREQ;
      if (!pick_found && bus.req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_id    = IdW'(scan_idx);
      end
    end
    pick_onehot[pick_id] = 1'b1;
  end

  // Transfers only happen with a registered grant; no word moves in the arbitration cycle.
  assign winc        = busy_q & bus.req_valid[grant_id_q] & ~bus.wFull;
  assign release_now = winc & (bus.req_last[grant_id_q] | (beat_cnt_q == BeatLast));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d    = StBurst;
          grant_d    = pick_onehot;
          grant_id_d = pick_id;
          beat_cnt_d = '0;
        end
      end
      StBurst: begin
        if (release_now || !bus.req_valid[grant_id_q]) begin
          state_d    = StIdle;
          grant_d    = '0;
          beat_cnt_d = '0;
        end else if (winc) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = StIdle;
        grant_d    = '0;
        beat_cnt_d = '0;
      end
    endcase
    busy_d = (state_d == StBurst);
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      grant_id_q <= IdLast;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.winc      = winc;
  assign bus.req_ready = bus.wFull ? '0 : grant_q;
  assign bus.wData     = busy_q ? bus.req_data[32'(grant_id_q) * DSIZE +: DSIZE] : '0;
  assign bus.grant     = grant_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = busy_q;

  a_grant_onehot: assert property (@(posedge wclk) disable iff (!wrst) $onehot0(bus.grant));
  a_winc_busy:    assert property (@(posedge wclk) disable iff (!wrst) bus.winc |-> bus.busy);
  a_ready_single: assert property (@(posedge wclk) disable iff (!wrst)
                                   $countones(bus.req_ready) <= 1);
  a_no_full_wr:   assert property (@(posedge wclk) disable iff (!wrst) !(bus.winc && bus.wFull));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a per-cycle vector table plus hand-written sequences
// for round-robin, full stall and mid-burst reset.
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned DSIZE     = 8;
  localparam int unsigned BURST_MAX = 8;

  logic wclk = 1'b0;
  logic wrst = 1'b0;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .DSIZE     (DSIZE),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  always #5 wclk = ~wclk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        full;
    logic [3:0]  e_grant;
    logic        e_winc;
    logic [7:0]  e_wdata;
    logic [3:0]  e_ready;
    logic        e_busy;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                     input logic f, input logic [3:0] g, input logic w, input logic [7:0] wd,
                     input logic [3:0] r, input logic b);
    vec_t x;
    x.valid = v; x.last = l; x.data = d; x.full = f;
    x.e_grant = g; x.e_winc = w; x.e_wdata = wd; x.e_ready = r; x.e_busy = b;
    vt.push_back(x);
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                       input logic f);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.wFull     = f;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic next_cycle();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst = 1'b0;
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    repeat (3) @(posedge wclk);
    #1;
    wrst = 1'b1;
  endtask

  // Invariants sampled on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge wclk);
      if (wrst) begin
        if (!$onehot0(bus.grant)) check("inv_grant_onehot", {28'h0, bus.grant}, 32'h0);
        if (bus.winc && !bus.busy) check("inv_winc_busy", 32'd1, 32'd0);
        if ($countones(bus.req_ready) > 1) check("inv_ready_count", {28'h0, bus.req_ready}, 0);
        if (bus.winc && bus.wFull) check("inv_winc_full", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    int words;
    int word;
    logic [3:0] eg;
    logic [7:0] ed;

    // Reset state with busy inputs: outputs must stay quiet.
    drive(4'b1111, 4'b1111, 32'hFFFF_FFFF, 1'b0);
    repeat (2) @(posedge wclk);
    #3;
    check("rst_grant", {28'h0, bus.grant}, 32'h0);
    check("rst_grant_id", {30'h0, bus.grant_id}, 32'd3);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_winc", {31'h0, bus.winc}, 32'h0);
    check("rst_ready", {28'h0, bus.req_ready}, 32'h0);
    check("rst_wdata", {24'h0, bus.wData}, 32'h0);
    do_reset();

    //  valid   last    data          full grant   winc wdata ready   busy
    add(4'b0100, 4'b0000, 32'h00A1_0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
    add(4'b0100, 4'b0000, 32'h00A1_0000, 0, 4'b0100, 1, 8'hA1, 4'b0100, 1);
    add(4'b0100, 4'b0000, 32'h00A2_0000, 0, 4'b0100, 1, 8'hA2, 4'b0100, 1);
    add(4'b0100, 4'b0100, 32'h00A3_0000, 0, 4'b0100, 1, 8'hA3, 4'b0100, 1);
    add(4'b0000, 4'b0000, 32'h0000_0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
    add(4'b0100, 4'b0100, 32'h00B1_0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
    add(4'b1101, 4'b0100, 32'hD0B1_00E0, 0, 4'b0100, 1, 8'hB1, 4'b0100, 1);
    add(4'b1001, 4'b0000, 32'hD000_00E0, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
    add(4'b1001, 4'b1000, 32'hD000_00E0, 0, 4'b1000, 1, 8'hD0, 4'b1000, 1);
    add(4'b0001, 4'b0000, 32'h0000_00E0, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
    add(4'b0001, 4'b0000, 32'h0000_00E0, 1, 4'b0001, 0, 8'hE0, 4'b0000, 1);
    add(4'b0001, 4'b0001, 32'h0000_00E0, 1, 4'b0001, 0, 8'hE0, 4'b0000, 1);
    add(4'b0001, 4'b0001, 32'h0000_00E0, 0, 4'b0001, 1, 8'hE0, 4'b0001, 1);
    add(4'b0000, 4'b0000, 32'h0000_0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
    add(4'b0010, 4'b0000, 32'h0000_1100, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
    add(4'b0010, 4'b0000, 32'h0000_1100, 0, 4'b0010, 1, 8'h11, 4'b0010, 1);
    add(4'b0010, 4'b0000, 32'h0000_1200, 0, 4'b0010, 1, 8'h12, 4'b0010, 1);
    add(4'b0100, 4'b0000, 32'h00C0_1300, 0, 4'b0010, 0, 8'h13, 4'b0010, 1);
    add(4'b0100, 4'b0000, 32'h00C0_0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
    add(4'b0100, 4'b0100, 32'h00C0_0000, 0, 4'b0100, 1, 8'hC0, 4'b0100, 1);
    add(4'b0000, 4'b0000, 32'h0000_0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);

    foreach (vt[i]) begin
      drive(vt[i].valid, vt[i].last, vt[i].data, vt[i].full);
      #3;
      check($sformatf("v%0d_grant", i), {28'h0, bus.grant}, {28'h0, vt[i].e_grant});
      check($sformatf("v%0d_winc", i), {31'h0, bus.winc}, {31'h0, vt[i].e_winc});
      check($sformatf("v%0d_wdata", i), {24'h0, bus.wData}, {24'h0, vt[i].e_wdata});
      check($sformatf("v%0d_ready", i), {28'h0, bus.req_ready}, {28'h0, vt[i].e_ready});
      check($sformatf("v%0d_busy", i), {31'h0, bus.busy}, {31'h0, vt[i].e_busy});
      @(posedge wclk);
      #1;
    end

    // Round-robin: all valid, never last -> 4 bursts of 8 with one idle cycle each.
    do_reset();
    words = 0;
    drive(4'b1111, 4'b0000, 32'h4433_2211, 1'b0);
    for (int c = 0; c < 36; c++) begin
      #3;
      eg = (c % 9 == 0) ? 4'b0000 : 4'(1 << (c / 9));
      check($sformatf("rr%0d_grant", c), {28'h0, bus.grant}, {28'h0, eg});
      check($sformatf("rr%0d_winc", c), {31'h0, bus.winc}, (c % 9 == 0) ? 32'd0 : 32'd1);
      if (c % 9 != 0) begin
        ed = 8'(8'h11 * ((c / 9) + 1));
        check($sformatf("rr%0d_wdata", c), {24'h0, bus.wData}, {24'h0, ed});
        check($sformatf("rr%0d_gid", c), {30'h0, bus.grant_id}, 32'(c / 9));
      end
      if (bus.winc) words++;
      next_cycle();
    end
    check("rr_words", 32'(words), 32'd32);
    #3;
    check("rr36_idle", {28'h0, bus.grant}, 32'h0);
    check("rr36_gid", {30'h0, bus.grant_id}, 32'd3);
    next_cycle();
    #3;
    check("rr37_wrap", {28'h0, bus.grant}, 32'h1);
    next_cycle();

    // Full stall after three beats: grant held, counter frozen, no lost or repeated word.
    do_reset();
    word = 1;
    drive(4'b0001, 4'b0000, 32'h0000_0001, 1'b0);
    #3;
    check("st_arb_grant", {28'h0, bus.grant}, 32'h0);
    next_cycle();
    for (int c = 1; c <= 14; c++) begin
      bus.req_data = 32'(word);
      bus.wFull    = (c >= 4 && c <= 8);
      #3;
      if (c == 14) begin
        check("st_release_grant", {28'h0, bus.grant}, 32'h0);
        check("st_release_busy", {31'h0, bus.busy}, 32'h0);
      end else if (bus.wFull) begin
        check($sformatf("st%0d_winc", c), {31'h0, bus.winc}, 32'd0);
        check($sformatf("st%0d_ready", c), {28'h0, bus.req_ready}, 32'h0);
        check($sformatf("st%0d_grant", c), {28'h0, bus.grant}, 32'h1);
      end else begin
        check($sformatf("st%0d_winc", c), {31'h0, bus.winc}, 32'd1);
        check($sformatf("st%0d_wdata", c), {24'h0, bus.wData}, 32'(word));
        word++;
      end
      next_cycle();
    end

    // Reset asserted during beat 4 of requester 0.
    do_reset();
    drive(4'b0001, 4'b0000, 32'h0000_0055, 1'b0);
    repeat (5) next_cycle();
    #1;
    check("rm_pre_winc", {31'h0, bus.winc}, 32'd1);
    wrst = 1'b0;
    #1;
    check("rm_grant", {28'h0, bus.grant}, 32'h0);
    check("rm_winc", {31'h0, bus.winc}, 32'd0);
    check("rm_ready", {28'h0, bus.req_ready}, 32'h0);
    check("rm_busy", {31'h0, bus.busy}, 32'd0);
    check("rm_gid", {30'h0, bus.grant_id}, 32'd3);
    next_cycle();
    wrst = 1'b1;
    bus.req_valid = 4'b1111;
    #3;
    check("rm_idle", {28'h0, bus.grant}, 32'h0);
    next_cycle();
    #3;
    check("rm_regrant", {28'h0, bus.grant}, 32'h1);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the write port of the async FIFO among NREQ write-domain requesters.
- Runs entirely in the write clock domain.
- Grants one requester at a time and holds the grant for a burst of up to BURST_MAX words, or until that requester marks its last word.
- Drives the FIFO's winc and wData, and stalls cleanly on wFull.

Parameters:
NREQ, 4, number of requesters (2..16)
DSIZE, 8, data word width; equals the FIFO's DSIZE
BURST_MAX, 8, maximum words per grant (1..256)

Ports:
wclk  in  1  write-domain clock
wrst  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester word valid
req_last  in  NREQ  per-requester end-of-packet flag, qualified by valid
req_data  in  NREQ*DSIZE  requester i data in bits [i*DSIZE +: DSIZE]
req_ready  out  NREQ  per-requester accept; word i is transferred when valid[i] & ready[i]
wFull  in  1  FIFO full flag (registered, write domain)
winc  out  1  FIFO write enable
wData  out  DSIZE  FIFO write data
grant  out  NREQ  one-hot current grant; all zero when idle
grant_id  out  $clog2(NREQ)  index of the granted requester; holds its last value when idle
busy  out  1  high while in state BURST

Behaviour:
- One clock, wclk. Reset is asynchronous, active-low on wrst.
- Reset values:
  - state=IDLE, grant=0, grant_id=NREQ-1, busy=0, beat_cnt=0.
  - winc=0, req_ready=0, wData=0. These follow combinationally from grant=0.
  - last_id=NREQ-1, so requester 0 wins first.
- States: IDLE, BURST.
- IDLE:
  - If any req_valid is high, pick the first valid index scanning last_id+1, last_id+2, … modulo NREQ.
  - Register grant/grant_id to that index, set last_id to it, clear beat_cnt, go to BURST.
  - Arbitration latency is 1 cycle. No transfer happens in IDLE.
- BURST, combinational outputs with g = grant_id:
  - winc = req_valid[g] & ~wFull.
  - req_ready[g] = ~wFull; every other req_ready bit is 0.
  - wData = req_data slice g, driven whenever granted; 0 when idle.
  - A transfer is a cycle with winc=1. Because the FIFO writes on winc & !wFull, exactly one word is written per transfer.
- BURST, on each transfer:
  - If req_last[g]=1 or beat_cnt==BURST_MAX-1: release. Next state is IDLE, grant=0, beat_cnt=0.
  - Otherwise beat_cnt increments.
- BURST while wFull=1:
  - No transfer, grant held, beat_cnt frozen. There is no timeout.
- BURST with req_valid[g]=0:
  - Release to IDLE next cycle, abandoning the grant. A requester must hold valid for the full packet to keep its grant.
- A release always costs one IDLE cycle before the next grant. Peak throughput is BURST_MAX words per BURST_MAX+1 cycles.
- Fairness: after a release, the released requester has lowest priority. No requester waits more than (NREQ-1) grants.
- beat_cnt width is $clog2(BURST_MAX)+1. It never wraps because the release fires at BURST_MAX-1.
- Simultaneous req_last and beat_cnt==BURST_MAX-1 on the same transfer: a single release.
- wFull rising in the same cycle as a last word: no transfer, no release. The word retries.
- Reset mid-burst: immediate return to reset values. A partial packet may already be in the FIFO; the arbiter does not undo it.
- Invariants (assertable):
  - grant is one-hot or zero.
  - winc implies busy.
  - $countones(req_ready) <= 1.
  - winc never asserts while wFull=1.

Test Plan:
- Reset then single requester: wrst low 3 cycles then high; req_valid=4'b0100 with 3 words, last on the third (0xA1,0xA2,0xA3). Expect grant=4'b0100 one cycle after valid, winc high 3 consecutive cycles, wData=A1,A2,A3, then grant=0.
- Round-robin: all 4 requesters continuously valid, never last, BURST_MAX=8. Expect grant order 0,1,2,3,0; each grant has exactly 8 winc pulses; 1 idle cycle between grants; 32 words in 36 cycles.
- Full stall: mid-burst, force wFull=1 for 5 cycles after beat 3. Expect winc=0 and req_ready=0 during the stall, grant held, beat_cnt=3 frozen; resumes at the 4th word with no loss or duplication.
- Last on first word: req 2 sends a 1-word packet with last=1. Expect 1 transfer, release, and req 3 (if valid) granted next, ahead of req 0.
- Valid drop: granted req 1 deasserts valid after 2 words. Expect release within 1 cycle and grant passed to the next valid requester.
- Reset mid-burst: wrst low during beat 4 of req 0. Expect grant=0, winc=0, req_ready=0 immediately; after reset, req 0 is granted first again.
